// File: rtl/uart_loader.sv
// Host-to-core program loader: decodes header words from the UART receive FIFO, streams
// payload words into instruction memory and returns one status word on the transmit FIFO.
module uart_loader #(
  parameter int unsigned DBIT   = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_empty,
  input  logic [DBIT-1:0]   i_r_data,
  output logic              o_rd_uart,
  input  logic              i_tx_full,
  output logic              o_wr_uart,
  output logic [DBIT-1:0]   o_w_data,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DBIT-1:0]   o_mem_data,
  output logic              o_busy,
  output logic              o_prog_done
);

  typedef enum logic [1:0] {StIdle, StData, StAck} state_e;

  localparam logic [7:0] CmdLoad = 8'hA5;
  localparam logic [7:0] CmdPing = 8'h5A;

  state_e            state_q, state_d;
  logic [11:0]       start_q, start_d;
  logic [11:0]       count_q, count_d;
  logic [11:0]       written_q, written_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_load_q, is_load_d;
  logic [DBIT-1:0]   w_data_q, w_data_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DBIT-1:0]   mem_data_q, mem_data_d;
  logic              prog_done_q, prog_done_d;
  logic              rd, wr;
  logic [7:0]        hdr_cmd;

  // Status words are 32 bits; zero-extend to the UART word width.
  function automatic logic [DBIT-1:0] status_word(input logic [31:0] w);
    logic [DBIT-1:0] tmp;
    tmp       = '0;
    tmp[31:0] = w;
    return tmp;
  endfunction

  assign hdr_cmd = i_r_data[31:24];

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    count_d     = count_q;
    written_d   = written_q;
    addr_d      = addr_q;
    is_load_d   = is_load_q;
    w_data_d    = w_data_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    prog_done_d = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!i_rx_empty) begin
          rd        = 1'b1;
          start_d   = i_r_data[23:12];
          count_d   = i_r_data[11:0];
          written_d = '0;
          addr_d    = i_r_data[12 +: ADDR_W];
          is_load_d = (hdr_cmd == CmdLoad);
          if (hdr_cmd == CmdLoad && i_r_data[11:0] != 12'h000) begin
            state_d = StData;
          end else if (hdr_cmd == CmdLoad || hdr_cmd == CmdPing) begin
            state_d  = StAck;
            w_data_d = status_word({8'hAC, i_r_data[23:12], 12'h000});
          end else begin
            state_d  = StAck;
            w_data_d = status_word({8'hEE, 16'h0000, hdr_cmd});
          end
        end
      end
      StData: begin
        if (!i_rx_empty) begin
          rd         = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_data_d = i_r_data;
          addr_d     = addr_q + ADDR_W'(1);
          written_d  = written_q + 12'd1;
          if (written_d == count_q) begin
            state_d  = StAck;
            w_data_d = status_word({8'hAC, start_q, written_d});
          end
        end
      end
      StAck: begin
        if (!i_tx_full) begin
          wr          = 1'b1;
          prog_done_d = is_load_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      start_q     <= '0;
      count_q     <= '0;
      written_q   <= '0;
      addr_q      <= '0;
      is_load_q   <= 1'b0;
      w_data_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      prog_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      count_q     <= count_d;
      written_q   <= written_d;
      addr_q      <= addr_d;
      is_load_q   <= is_load_d;
      w_data_q    <= w_data_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      prog_done_q <= prog_done_d;
    end
  end

  // FIFO strobes are Mealy; gate with reset so neither FIFO moves while held.
  assign o_rd_uart   = rd & i_reset;
  assign o_wr_uart   = wr & i_reset;
  assign o_w_data    = w_data_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_busy      = (state_q != StIdle);
  assign o_prog_done = prog_done_q;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: directed headers/payloads push expected memory writes and
// status words into queues; a monitor pops and compares whenever the DUT presents them.
module tb_uart_loader;

  localparam int unsigned DBIT   = 32;
  localparam int unsigned ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DBIT-1:0]   data;
  } mem_t;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_rx_empty = 1'b1;
  logic [DBIT-1:0]   i_r_data = '0;
  logic              o_rd_uart;
  logic              i_tx_full = 1'b0;
  logic              o_wr_uart;
  logic [DBIT-1:0]   o_w_data;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DBIT-1:0]   o_mem_data;
  logic              o_busy;
  logic              o_prog_done;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int done_pulses = 0;
  mem_t exp_mem[$];
  logic [DBIT-1:0] exp_tx[$];
  int we_cycles[$];

  uart_loader #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx_empty (i_rx_empty),
    .i_r_data   (i_r_data),
    .o_rd_uart  (o_rd_uart),
    .i_tx_full  (i_tx_full),
    .o_wr_uart  (o_wr_uart),
    .o_w_data   (o_w_data),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_busy     (o_busy),
    .o_prog_done(o_prog_done)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples between edges, after the driver has settled its inputs.
  initial begin
    forever begin
      @(negedge i_clk);
      #2;
      if (i_reset) begin
        check("rd_wr_exclusive", 64'(o_rd_uart & o_wr_uart), 64'd0);
        if (o_mem_we) begin
          we_cycles.push_back(cycle);
          if (exp_mem.size() == 0) begin
            check("unexpected_mem_write", {22'd0, o_mem_addr, o_mem_data}, 64'd0);
          end else begin
            mem_t m;
            m = exp_mem.pop_front();
            check("mem_addr", 64'(o_mem_addr), 64'(m.addr));
            check("mem_data", 64'(o_mem_data), 64'(m.data));
          end
        end
        if (o_wr_uart) begin
          if (exp_tx.size() == 0) begin
            check("unexpected_tx_push", 64'(o_w_data), 64'd0);
          end else begin
            check("tx_word", 64'(o_w_data), 64'(exp_tx.pop_front()));
          end
        end
        if (o_prog_done) done_pulses++;
      end
    end
  end

  task automatic rx_word(input logic [DBIT-1:0] w);
    int t;
    t = 0;
    @(negedge i_clk);
    i_r_data   = w;
    i_rx_empty = 1'b0;
    #1;
    while (!o_rd_uart && t < 200) begin
      @(negedge i_clk);
      #1;
      t++;
    end
    if (t >= 200) check("rx_pop_timeout", 64'd1, 64'd0);
    @(posedge i_clk);
    #1 i_rx_empty = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || exp_mem.size() != 0) && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    check(name, 64'(t < 200), 64'd1);
    idle_cycles(3);
    #3 check({name, "_idle"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_mem_we", 64'(o_mem_we), 64'd0);
    check("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check("rst_mem_data", 64'(o_mem_data), 64'd0);
    check("rst_w_data", 64'(o_w_data), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_prog_done", 64'(o_prog_done), 64'd0);
    i_rx_empty = 1'b0;
    #1 check("rst_rd_uart", 64'(o_rd_uart), 64'd0);
    i_rx_empty = 1'b1;
    idle_cycles(2);
    i_reset = 1'b1;
    idle_cycles(2);

    // PING
    exp_tx.push_back(32'hAC000000);
    rx_word(32'h5A000000);
    drain("ping");
    check("ping_no_done", 64'(done_pulses), 64'd0);

    // LOAD back-to-back
    we_cycles.delete();
    exp_mem.push_back('{addr: 10'h010, data: 32'h11});
    exp_mem.push_back('{addr: 10'h011, data: 32'h22});
    exp_mem.push_back('{addr: 10'h012, data: 32'h33});
    exp_tx.push_back(32'hAC010003);
    rx_word(32'hA5010003);
    rx_word(32'h11);
    rx_word(32'h22);
    rx_word(32'h33);
    drain("load_b2b");
    check("b2b_nwrites", 64'(we_cycles.size()), 64'd3);
    if (we_cycles.size() == 3) begin
      check("b2b_consec1", 64'(we_cycles[1] - we_cycles[0]), 64'd1);
      check("b2b_consec2", 64'(we_cycles[2] - we_cycles[1]), 64'd1);
    end
    check("b2b_done", 64'(done_pulses), 64'd1);

    // LOAD with wrap and gaps
    exp_mem.push_back('{addr: 10'h3FE, data: 32'hDEADBEEF});
    exp_mem.push_back('{addr: 10'h3FF, data: 32'h01234567});
    exp_mem.push_back('{addr: 10'h000, data: 32'hCAFEF00D});
    exp_tx.push_back(32'hAC3FE003);
    rx_word(32'hA53FE003);
    idle_cycles(5);
    #3 check("gap_busy", 64'(o_busy), 64'd1);
    rx_word(32'hDEADBEEF);
    idle_cycles(5);
    #3 check("gap_busy2", 64'(o_busy), 64'd1);
    rx_word(32'h01234567);
    idle_cycles(5);
    rx_word(32'hCAFEF00D);
    drain("load_wrap");
    check("wrap_done", 64'(done_pulses), 64'd2);

    // Unknown command
    exp_tx.push_back(32'hEE000077);
    rx_word(32'h77123456);
    drain("nack");
    check("nack_no_done", 64'(done_pulses), 64'd2);

    // LOAD N=0 with tx full
    @(negedge i_clk);
    i_tx_full = 1'b1;
    exp_tx.push_back(32'hAC000000);
    rx_word(32'hA5000000);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      #1;
      check("full_no_wr", 64'(o_wr_uart), 64'd0);
      check("full_busy", 64'(o_busy), 64'd1);
    end
    @(negedge i_clk);
    i_tx_full = 1'b0;
    #1 check("full_first_push", 64'(o_wr_uart), 64'd1);
    drain("load_n0");
    check("n0_done", 64'(done_pulses), 64'd3);

    // Reset mid-LOAD
    exp_mem.push_back('{addr: 10'h020, data: 32'h0000000A});
    exp_mem.push_back('{addr: 10'h021, data: 32'h0000000B});
    rx_word(32'hA5020004);
    rx_word(32'h0000000A);
    rx_word(32'h0000000B);
    idle_cycles(2);
    i_rx_empty = 1'b0;
    i_reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    check("mid_rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check("mid_rst_mem_data", 64'(o_mem_data), 64'd0);
    check("mid_rst_rd", 64'(o_rd_uart), 64'd0);
    check("mid_rst_wr", 64'(o_wr_uart), 64'd0);
    check("mid_rst_w_data", 64'(o_w_data), 64'd0);
    idle_cycles(2);
    i_rx_empty = 1'b1;
    i_reset = 1'b1;
    check("mid_rst_writes_seen", 64'(exp_mem.size()), 64'd0);
    exp_tx.push_back(32'hAC000000);
    rx_word(32'h5A000000);
    drain("post_rst_ping");

    check("final_done_pulses", 64'(done_pulses), 64'd3);
    check("final_tx_empty", 64'(exp_tx.size()), 64'd0);
    check("final_mem_empty", 64'(exp_mem.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Command-level client of the UART block: pops 32-bit words from the UART receive FIFO, decodes a header command, streams payload words into instruction memory, and returns one status word through the UART transmit FIFO. Sits between the `uart` top and the pipeline's instruction memory in the IF stage. It is the host-to-core program loader.

## Interface
Parameters:
- `DBIT`, 32, data word width. Must match the UART word width and be at least 32.
- `ADDR_W`, 10, instruction-memory address width, ≤ 12.

Ports:
- `i_clk`  in  1  clock
- `i_reset`  in  1  reset, asynchronous, active-low
- `i_rx_empty`  in  1  UART receive FIFO empty
- `i_r_data`  in  DBIT  UART receive FIFO head word (first-word-fall-through)
- `o_rd_uart`  out  1  pop receive FIFO
- `i_tx_full`  in  1  UART transmit FIFO full
- `o_wr_uart`  out  1  push transmit FIFO
- `o_w_data`  out  DBIT  status word to transmit
- `o_mem_we`  out  1  instruction-memory write enable
- `o_mem_addr`  out  ADDR_W  write address
- `o_mem_data`  out  DBIT  write data
- `o_busy`  out  1  high whenever state ≠ IDLE
- `o_prog_done`  out  1  one-cycle pulse when a LOAD status word is pushed

## Operation
- Header word fields: [31:24] cmd, [23:12] start address, [11:0] count N.
  - `0xA5` LOAD: write N payload words starting at the start address, then send ACK.
  - `0x5A` PING: send ACK with N=0 and no memory access.
  - Any other cmd: send NACK.
- Address fields are truncated to ADDR_W bits. Address increments modulo 2^ADDR_W and wraps silently.
- ACK word: {8'hAC, 12'(start address), 12'(words written)}.
- NACK word: {8'hEE, 16'h0000, cmd}.
- States:
  - IDLE: when `!i_rx_empty`, pop the header and latch the fields.
    - LOAD with N>0 → DATA.
    - LOAD with N=0, PING, or unknown cmd → ACK.
  - DATA: when `!i_rx_empty`, pop a word and issue a memory write.
    - After the Nth pop → ACK. Otherwise stay in DATA.
    - An empty FIFO stalls indefinitely; there is no timeout.
  - ACK: when `!i_tx_full`, push the status word → IDLE. A full FIFO stalls in ACK.
- `o_rd_uart` = (IDLE or DATA) && `!i_rx_empty`, combinational (Mealy). `i_r_data` is captured on the same edge.
- `o_wr_uart` = ACK && `!i_tx_full`, combinational. `o_w_data` is driven from a register loaded on entry to ACK and is stable throughout ACK.
- `o_mem_we`, `o_mem_addr`, `o_mem_data` are registered and valid in the cycle after the pop. `o_mem_we` is a one-cycle pulse per word. Data is passed unmodified.
- Words-written counter is 12 bits and is compared against N for termination.

## Timing
- Reset (asynchronous, `i_reset`=0) sets state to IDLE and clears all registered outputs:
  - `o_mem_we`=0, `o_mem_addr`=0, `o_mem_data`=0, `o_w_data`=0, `o_prog_done`=0, `o_busy`=0.
  - `o_rd_uart`=0 and `o_wr_uart`=0 while in reset.
- Reset mid-LOAD abandons the transfer: no ACK is sent, and memory writes already issued are not undone.
- Throughput is one payload word per cycle while the FIFO is non-empty.
- Header popped at edge k with N>0: the first data pop can occur in cycle k+1, and the first `o_mem_we` is in cycle k+2.
- The last data pop at edge j enters ACK. The push can occur in cycle j+1, coincident with the final `o_mem_we`.
- PING, NACK, or N=0: header popped at edge k, push in cycle k+1 if `!i_tx_full`.
- `o_prog_done` is asserted in the cycle after the LOAD ACK push edge, for one cycle only.
- `o_rd_uart` and `o_wr_uart` are never high together.

## Test plan
- PING `0x5A000000`, tx not full → one push of `0xAC000000`; no `o_mem_we`; `o_prog_done` stays 0.
- LOAD `0xA5010003` followed by `0x11`, `0x22`, `0x33` back-to-back → writes to addresses 0x010, 0x011, 0x012 on consecutive cycles; then push `0xAC010003`; one `o_prog_done` pulse.
- LOAD `0xA53FE003` (ADDR_W=10), payload gaps of 5 cycles between words → writes to 0x3FE, 0x3FF, 0x000; stalls hold DATA with `o_busy`=1; ACK is `0xAC3FE003`.
- Unknown header `0x77123456` → push `0xEE000077`; state returns to IDLE.
- LOAD `0xA5000000` with `i_tx_full`=1 for 10 cycles → no memory writes; `o_wr_uart`=0 while full; `0xAC000000` pushed on the first not-full cycle.
- Reset asserted after 2 of 4 payload words → outputs cleared immediately; no ACK; the next header `0x5A000000` is handled normally.
